// File: rtl/serial_subtractor.sv
// Serial subtractor: computes a - b - bin one STEP-bit slice per clock,
// LSB slice first, and reports the difference, borrow-out and signed overflow
// with a one-cycle done pulse once all WIDTH/STEP slices have been processed.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, next_state;

  // work_reg starts out holding the minuend; every RUN cycle its low slice is
  // consumed and the freshly computed difference slice enters at the top, so
  // after N cycles it holds the complete result.
  logic [WIDTH-1:0] work_reg;
  logic [WIDTH-1:0] work_next;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  logic             a_msb;
  logic             b_msb;
  logic [CNT_W-1:0] cnt;

  logic [STEP-1:0]  slice_diff;
  logic             slice_borrow;
  logic             accept;
  logic             last;

  // State register, cleared asynchronously so reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept start only in IDLE, leave RUN on the last slice.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(N - 1)) begin
          last       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Ripple full-subtractor chain across the current STEP-bit slice.
  always_comb begin : slice_chain
    logic c;
    logic x;
    logic y;
    slice_diff = '0;
    c          = borrow_reg;
    for (int i = 0; i < STEP; i++) begin
      x             = work_reg[i];
      y             = b_reg[i];
      slice_diff[i] = x ^ y ^ c;
      c             = (~x & y) | (~(x ^ y) & c);
    end
    slice_borrow = c;
  end

  generate
    if (STEP == WIDTH) begin : g_single_slice
      assign work_next = slice_diff;
    end else begin : g_multi_slice
      assign work_next = {slice_diff, work_reg[WIDTH-1:STEP]};
    end
  endgenerate

  // Operand capture on accept, then shift one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg   <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      work_reg   <= a;
      b_reg      <= b;
      borrow_reg <= bin;
      a_msb      <= a[WIDTH-1];
      b_msb      <= b[WIDTH-1];
      cnt        <= '0;
    end else if (busy) begin
      work_reg   <= work_next;
      b_reg      <= b_reg >> STEP;
      borrow_reg <= slice_borrow;
      cnt        <= cnt + 1'b1;
    end
  end

  // Result registers only change when an operation completes, so no partial
  // value is ever visible on diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        diff <= work_next;
        bout <= slice_borrow;
        ovf  <= (a_msb ^ b_msb) & (work_next[WIDTH-1] ^ a_msb);
      end
    end
  end

endmodule
